ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares one port of the 64 KB dual-port data RAM between up to NUM_REQ bus masters (CPU data port, blitter, display fetch). Each cycle it accepts at most one request, registers it onto the RAM port, and routes the read data back to the originating master two cycles after acceptance. It sits between the masters' valid/ready request buses and the RAM port pins, with per-master burst lock and optional round-robin fairness.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 16, requester byte-address width
- RAM_AW, 14, RAM word-address width (= ADDR_W-2)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  request present per master
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  keep grant after this transfer
- req_addr  in  NUM_REQ x ADDR_W  byte address; bits [1:0] ignored
- req_wdata  in  NUM_REQ x 32  write data
- req_byteena  in  NUM_REQ x 4  write byte enables
- rsp_valid  out  NUM_REQ  read data valid for master i (one-hot or zero)
- rsp_rdata  out  32  read data, shared by all masters
- ram_address  out  RAM_AW  to RAM port
- ram_data  out  32  to RAM port
- ram_byteena  out  4  to RAM port
- ram_wren  out  1  to RAM port
- ram_q  in  32  from RAM port (registered in RAM, 1-cycle latency)

## Operation
- Transfer on master i: req_valid[i] && req_ready[i] at a rising edge.
- Arbitration (combinational, cycle T): if lock held by owner k, only k eligible; else winner chosen among req_valid by priority rule (see Configuration). req_ready asserted only to winner; zero when no eligible request.
- Locked owner not asserting valid: idle cycle, nobody else granted.
- Lock: transfer with req_lock[i]=1 sets lock owner = i; transfer by owner with req_lock=0 releases. Lock only changes on transfers.
- Accepted request registered at edge ending T: ram_address=req_addr[ADDR_W-1:2], ram_data, ram_byteena, ram_wren=req_write. Non-transfer cycle: ram_wren=0, other ram_* hold previous values.
- Response tag pipeline, 2 stages: {valid=!write, id}. Stage 2 valid drives rsp_valid[id]; rsp_rdata = ram_q passthrough.
- Writes produce no response. Write with byteena 0000 still asserts ram_wren (no memory change).
- Read after write to same address from any master returns the new data (RAM sees write in earlier cycle).

## Timing
- Throughput: one transfer per cycle, back-to-back, any master mix.
- Read latency: accepted at edge T -> ram_* valid cycle T+1 -> rsp_valid during cycle T+2.
- Reset (async, any time, mid-lock or mid-pipeline): req_ready=0, rsp_valid=0, ram_wren=0, ram_address=0, ram_data=0, ram_byteena=0, lock cleared, RR pointer=0, tag pipeline flushed; in-flight reads are dropped, no response.
- req_ready forced 0 while reset is high.

## Configuration
- RAM_ARB_RR_EN defined: round-robin; search starts at pointer p, wrapping NUM_REQ-1 -> 0; after unlocked transfer by i, p = (i+1) mod NUM_REQ. Locked transfers do not move p.
- Not defined: fixed priority, lowest index wins; no pointer register.

## Structure
- Package ram_arb_pkg: NUM_REQ/ADDR_W/RAM_AW defaults, tag typedef {valid, id[$clog2(NUM_REQ)-1:0]}, request struct typedef {write, lock, addr, wdata, byteena}.
- Sub-module ram_arb_pick: pure combinational winner select (valid vector, pointer, lock owner/valid) -> one-hot grant + index; contains the RAM_ARB_RR_EN mux.

## Test plan
- Single read: master 1 reads 0x0104 with RAM word 0x41 = 0xDEADBEEF -> req_ready[1] cycle T, ram_address=0x41 cycle T+1, rsp_valid=3'b010 with 0xDEADBEEF cycle T+2.
- Write then read: master 0 writes 0x12345678 byteena 0011 to 0x0200 (old 0xAAAAAAAA), master 2 reads 0x0200 next cycle -> master 2 receives 0xAAAA5678.
- Contention, RR_EN: all three valid continuously -> grant order 0,1,2,0,1,2; without macro -> 0 every cycle.
- Lock: master 2 issues 4 reads with lock=1,1,1,0 while masters 0,1 valid, one idle cycle in the middle -> masters 0,1 get no ready until after 4th transfer; idle cycle grants nobody.
- Reset mid-flight: reads accepted at T and T+1, reset pulsed during T+1 -> no rsp_valid at T+2/T+3, all outputs zero, lock cleared.
- Wrap: read 0xFFFC -> ram_address=0x3FFF, correct data returned.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 3;
  localparam int unsigned DEF_ADDR_W  = 16;
  localparam int unsigned DEF_RAM_AW  = 14;

  // Tag and request fields are sized for the largest supported configuration.
  localparam int unsigned MAX_NUM_REQ = 8;
  localparam int unsigned ID_W        = $clog2(MAX_NUM_REQ);
  localparam int unsigned MAX_ADDR_W  = 32;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic                  write;
    logic                  lock;
    logic [MAX_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            byteena;
  } req_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select for ram_arbiter: lock owner first, then priority.
// Optional feature macro: RAM_ARB_RR_EN (round-robin from i_ptr); default is lowest index wins.
module ram_arb_pick
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
`ifdef RAM_ARB_RR_EN
  input  logic [IDW-1:0]     i_ptr,
`endif
  input  logic               i_lock_vld,
  input  logic [IDW-1:0]     i_lock_own,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx
);

  // Loops run high-to-low so the last hit, i.e. the highest priority, wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    if (i_lock_vld) begin
      if (i_valid[i_lock_own]) begin
        o_grant[i_lock_own] = 1'b1;
        o_idx               = i_lock_own;
      end
    end else begin
`ifdef RAM_ARB_RR_EN
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (i_valid[i] && (IDW'(i) < i_ptr)) begin
          o_grant    = '0;
          o_grant[i] = 1'b1;
          o_idx      = IDW'(i);
        end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (i_valid[i] && (IDW'(i) >= i_ptr)) begin
          o_grant    = '0;
          o_grant[i] = 1'b1;
          o_idx      = IDW'(i);
        end
      end
`else
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (i_valid[i]) begin
          o_grant    = '0;
          o_grant[i] = 1'b1;
          o_idx      = IDW'(i);
        end
      end
`endif
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between NUM_REQ masters with burst lock and 2-cycle read return.
// Optional feature macro: RAM_ARB_RR_EN selects round-robin arbitration.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned RAM_AW  = DEF_RAM_AW
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ-1:0]        i_req_write,
  input  logic [NUM_REQ-1:0]        i_req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*32-1:0]     i_req_wdata,
  input  logic [NUM_REQ*4-1:0]      i_req_byteena,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [31:0]               o_rsp_rdata,
  output logic [RAM_AW-1:0]         o_ram_address,
  output logic [31:0]               o_ram_data,
  output logic [3:0]                o_ram_byteena,
  output logic                      o_ram_wren,
  input  logic [31:0]               i_ram_q
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_idx;
  logic               w_xfer;
  req_t               w_sel;
  logic               w_unused_addr;

  logic               r_lock_vld;
  logic [IDW-1:0]     r_lock_own;
  logic [RAM_AW-1:0]  r_ram_address;
  logic [31:0]        r_ram_data;
  logic [3:0]         r_ram_byteena;
  logic               r_ram_wren;
  tag_t               r_tag1;
  tag_t               r_tag2;

`ifdef RAM_ARB_RR_EN
  logic [IDW-1:0]     r_ptr;
`endif

  ram_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .i_valid    (i_req_valid),
`ifdef RAM_ARB_RR_EN
    .i_ptr      (r_ptr),
`endif
    .i_lock_vld (r_lock_vld),
    .i_lock_own (r_lock_own),
    .o_grant    (w_grant),
    .o_idx      (w_idx)
  );

  always_comb begin
    w_sel.write   = i_req_write[w_idx];
    w_sel.lock    = i_req_lock[w_idx];
    w_sel.addr    = MAX_ADDR_W'(i_req_addr[w_idx*ADDR_W +: ADDR_W]);
    w_sel.wdata   = i_req_wdata[w_idx*32 +: 32];
    w_sel.byteena = i_req_byteena[w_idx*4 +: 4];
  end

  assign w_xfer        = |w_grant;
  assign o_req_ready   = i_reset ? '0 : w_grant;
  assign w_unused_addr = ^{w_sel.addr[MAX_ADDR_W-1:RAM_AW+2], w_sel.addr[1:0]};

  // Lock follows the lock bit of every transfer; only the owner can transfer while held.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_lock_vld <= 1'b0;
      r_lock_own <= '0;
    end else if (w_xfer) begin
      r_lock_vld <= w_sel.lock;
      r_lock_own <= w_idx;
    end
  end

`ifdef RAM_ARB_RR_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (w_xfer && !r_lock_vld) begin
      r_ptr <= (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_ram_byteena <= '0;
      r_ram_wren    <= 1'b0;
    end else begin
      r_ram_wren <= w_xfer && w_sel.write;
      if (w_xfer) begin
        r_ram_address <= w_sel.addr[RAM_AW+1:2];
        r_ram_data    <= w_sel.wdata;
        r_ram_byteena <= w_sel.byteena;
      end
    end
  end

  // Tag stage 2 lines up with the RAM's registered read data.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tag1 <= '0;
      r_tag2 <= '0;
    end else begin
      r_tag1.valid <= w_xfer && !w_sel.write;
      r_tag1.id    <= ID_W'(w_idx);
      r_tag2       <= r_tag1;
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_rsp_valid[i] = r_tag2.valid && (r_tag2.id == ID_W'(i));
    end
  end

  assign o_rsp_rdata   = i_ram_q;
  assign o_ram_address = r_ram_address;
  assign o_ram_data    = r_ram_data;
  assign o_ram_byteena = r_ram_byteena;
  assign o_ram_wren    = r_ram_wren;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios then random traffic vs a reference model.
module tb_ram_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]  valid, write, lock;
  logic [15:0]   addr  [N];
  logic [31:0]   wdata [N];
  logic [3:0]    be    [N];

  logic [N*16-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N*4-1:0]  req_be;
  assign req_addr  = {addr[2], addr[1], addr[0]};
  assign req_wdata = {wdata[2], wdata[1], wdata[0]};
  assign req_be    = {be[2], be[1], be[0]};

  logic [N-1:0] req_ready, rsp_valid;
  logic [31:0]  rsp_rdata, ram_data, ram_q;
  logic [13:0]  ram_address;
  logic [3:0]   ram_byteena;
  logic         ram_wren;

  ram_arbiter dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_req_valid   (valid),
    .o_req_ready   (req_ready),
    .i_req_write   (write),
    .i_req_lock    (lock),
    .i_req_addr    (req_addr),
    .i_req_wdata   (req_wdata),
    .i_req_byteena (req_be),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_rdata   (rsp_rdata),
    .o_ram_address (ram_address),
    .o_ram_data    (ram_data),
    .o_ram_byteena (ram_byteena),
    .o_ram_wren    (ram_wren),
    .i_ram_q       (ram_q)
  );

  // RAM with registered read, old-data on same-cycle collision.
  logic [31:0] mem [16384];
  always @(posedge clk) begin
    if (ram_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_byteena[b]) mem[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
      end
    end
    ram_q <= mem[ram_address];
  end

  // Reference model state
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] shadow [16384];
  rsp_t        rspq [$];
  bit          lock_held;
  int          lock_owner;
  int          ptr;
  int          cyc;
  logic        exp_wren;
  logic [13:0] exp_addr;
  logic [31:0] exp_data;
  logic [3:0]  exp_be;

  logic [N-1:0] last_grant, last_rv;
  logic [31:0]  last_rd;
  logic [N-1:0] grants [6];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_wren"}, ram_wren, 0);
    chk({tag, "_address"}, ram_address, 0);
    chk({tag, "_data"}, ram_data, 0);
    chk({tag, "_byteena"}, ram_byteena, 0);
  endtask

  task automatic model_reset();
    lock_held  = 1'b0;
    lock_owner = 0;
    ptr        = 0;
    rspq.delete();
    exp_wren   = 1'b0;
    exp_addr   = '0;
    exp_data   = '0;
    exp_be     = '0;
  endtask

  task automatic set_req(input int m, input logic v, input logic w, input logic l,
                         input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
    valid[m] = v;
    write[m] = w;
    lock[m]  = l;
    addr[m]  = a;
    wdata[m] = d;
    be[m]    = b;
  endtask

  task automatic clear_req();
    valid = '0;
    write = '0;
    lock  = '0;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance the model.
  task automatic tick();
    int           win;
    int           w;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic [31:0]  exp_rd;
    @(negedge clk);
    win = -1;
    if (lock_held) begin
      if (valid[lock_owner]) win = lock_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
`ifdef RAM_ARB_RR_EN
        if (win < 0 && valid[(ptr + k) % N]) win = (ptr + k) % N;
`else
        if (win < 0 && valid[k]) win = k;
`endif
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("ram_wren", ram_wren, exp_wren);
    chk("ram_address", ram_address, exp_addr);
    chk("ram_data", ram_data, exp_data);
    chk("ram_byteena", ram_byteena, exp_be);
    exp_rv = '0;
    exp_rd = '0;
    if (rspq.size() > 0 && rspq[0].due == cyc) begin
      exp_rv[rspq[0].id] = 1'b1;
      exp_rd = rspq[0].data;
      void'(rspq.pop_front());
    end
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv != '0) chk("rsp_rdata", rsp_rdata, exp_rd);
    last_grant = req_ready;
    last_rv    = rsp_valid;
    last_rd    = rsp_rdata;
    exp_wren = 1'b0;
    if (win >= 0) begin
      w        = int'(addr[win]) / 4;
      exp_wren = write[win];
      exp_addr = 14'(w);
      exp_data = wdata[win];
      exp_be   = be[win];
      if (write[win]) begin
        for (int b = 0; b < 4; b++) begin
          if (be[win][b]) shadow[w][8*b +: 8] = wdata[win][8*b +: 8];
        end
      end else begin
        rspq.push_back('{cyc + 2, win, shadow[w]});
      end
      if (!lock_held) ptr = (win + 1) % N;
      lock_held  = lock[win];
      lock_owner = win;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    clear_req();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    for (int i = 0; i < 16384; i++) begin
      mem[i]    = $urandom;
      shadow[i] = mem[i];
    end
    mem[14'h0041] = 32'hDEADBEEF;  shadow[14'h0041] = 32'hDEADBEEF;
    mem[14'h0080] = 32'hAAAAAAAA;  shadow[14'h0080] = 32'hAAAAAAAA;
    mem[14'h3FFF] = 32'h600DF00D;  shadow[14'h3FFF] = 32'h600DF00D;
    #2;
    chk_zero_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc = 0;

    // Single read by master 1
    set_req(1, 1'b1, 1'b0, 1'b0, 16'h0104, 32'h0, 4'h0);
    tick();
    chk("single_ready", last_grant, 3'b010);
    clear_req();
    chk("single_addr", ram_address, 14'h0041);
    tick();
    tick();
    chk("single_rsp_valid", last_rv, 3'b010);
    chk("single_rdata", last_rd, 32'hDEADBEEF);

    // Partial write by master 0, read-back by master 2 next cycle
    set_req(0, 1'b1, 1'b1, 1'b0, 16'h0200, 32'h12345678, 4'b0011);
    tick();
    clear_req();
    set_req(2, 1'b1, 1'b0, 1'b0, 16'h0200, 32'h0, 4'h0);
    tick();
    clear_req();
    tick();
    tick();
    chk("wr_rd_rsp_valid", last_rv, 3'b100);
    chk("wr_rd_rdata", last_rd, 32'hAAAA5678);

    // Continuous contention from all three masters
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 16'(32'h0300 + 4 * i), 32'h0, 4'h0);
    for (int c = 0; c < 6; c++) begin
      tick();
      grants[c] = last_grant;
    end
    for (int c = 0; c < 6; c++) begin
`ifdef RAM_ARB_RR_EN
      chk("contention_order", grants[c], 3'(1 << (c % 3)));
`else
      chk("contention_order", grants[c], 3'b001);
`endif
    end
    clear_req();
    repeat (3) tick();

    // Locked burst by master 2 with an idle cycle in the middle
    set_req(2, 1'b1, 1'b0, 1'b1, 16'h0400, 32'h0, 4'h0);
    tick();
    grants[0] = last_grant;
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0500, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 16'h0504, 32'h0, 4'h0);
    set_req(2, 1'b1, 1'b0, 1'b1, 16'h0404, 32'h0, 4'h0);
    tick();
    grants[1] = last_grant;
    valid[2] = 1'b0;
    tick();
    grants[2] = last_grant;
    set_req(2, 1'b1, 1'b0, 1'b1, 16'h0408, 32'h0, 4'h0);
    tick();
    grants[3] = last_grant;
    set_req(2, 1'b1, 1'b0, 1'b0, 16'h040C, 32'h0, 4'h0);
    tick();
    grants[4] = last_grant;
    valid[2] = 1'b0;
    tick();
    grants[5] = last_grant;
    chk("lock_xfer1", grants[0], 3'b100);
    chk("lock_xfer2", grants[1], 3'b100);
    chk("lock_idle", grants[2], 3'b000);
    chk("lock_xfer3", grants[3], 3'b100);
    chk("lock_xfer4", grants[4], 3'b100);
    chk("lock_released", grants[5], 3'b001);
    clear_req();
    repeat (3) tick();

    // Reset while a lock is held and reads are in flight
    set_req(2, 1'b1, 1'b0, 1'b1, 16'h0104, 32'h0, 4'h0);
    tick();
    set_req(2, 1'b1, 1'b0, 1'b1, 16'h0200, 32'h0, 4'h0);
    tick();
    set_req(2, 1'b1, 1'b0, 1'b1, 16'h0204, 32'h0, 4'h0);
    #1 rst = 1'b1;
    #1 chk_zero_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc++;
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0104, 32'h0, 4'h0);
    lock[2] = 1'b0;
    tick();
    chk("post_reset_lock_cleared", last_grant, 3'b001);
    clear_req();
    tick();
    chk("post_reset_no_rsp", last_rv, 3'b000);
    tick();
    chk("post_reset_new_rsp", last_rv, 3'b001);

    // Top-of-memory address
    set_req(1, 1'b1, 1'b0, 1'b0, 16'hFFFC, 32'h0, 4'h0);
    tick();
    clear_req();
    chk("wrap_addr", ram_address, 14'h3FFF);
    tick();
    tick();
    chk("wrap_rdata", last_rd, 32'h600DF00D);

    // Random mixed traffic
    for (int r = 0; r < 400; r++) begin
      for (int m = 0; m < N; m++) begin
        logic [13:0] wd;
        wd = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'(32'h40 + $urandom_range(0, 7));
        set_req(m, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0,
                {wd, 2'($urandom)}, $urandom, 4'($urandom));
      end
      tick();
    end
    clear_req();
    repeat (4) tick();
    chk("drain_empty", rspq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
